load_store_unit: RTL and testbench

Memory stage directly downstream of the scheduling queue. Accepts one load/store request at a time from the scheduler front register and the AGU, and performs it as one or two byte beats on the 8-bit core memory bus. Stalls the scheduler with lsu_wait while busy. Returns load results, with a reservation-station tag, to the station write-back inputs (lsu_data_in / lsu_data_tag / lsu_data_wb).

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Scheduler-side request/write-back signals and the 8-bit core memory bus.
// slave = LSU side; master = scheduler + memory side.
interface load_store_unit_if;
    logic        lsu_rq_start;
    logic        lsu_rq_cmd;
    logic        lsu_rq_width;
    logic        lsu_rq_tag;
    logic [15:0] lsu_rq_addr;
    logic [15:0] lsu_rq_wdata;
    logic        lsu_wait;
    logic [15:0] lsu_data_in;
    logic        lsu_data_tag;
    logic        lsu_data_wb;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport slave (
        input  lsu_rq_start, lsu_rq_cmd, lsu_rq_width, lsu_rq_tag, lsu_rq_addr, lsu_rq_wdata,
        input  mem_rdata, mem_ready,
        output lsu_wait, lsu_data_in, lsu_data_tag, lsu_data_wb,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output lsu_rq_start, lsu_rq_cmd, lsu_rq_width, lsu_rq_tag, lsu_rq_addr, lsu_rq_wdata,
        output mem_rdata, mem_ready,
        input  lsu_wait, lsu_data_in, lsu_data_tag, lsu_data_wb,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: one request at a time, split into one or two little-endian
// byte beats on the 8-bit memory bus; load results return with their station tag.
module load_store_unit #(
    parameter bit SIGN_EXTEND_BYTE = 1'b0
) (
    input  logic               clk,
    input  logic               a_rst,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2} state_t;

    typedef struct packed {
        logic        cmd;
        logic        width;
        logic        tag;
        logic [15:0] addr;
        logic [15:0] wdata;
    } lsu_req_t;

    state_t      state, state_nxt;
    lsu_req_t    req;
    logic [7:0]  res_lo;
    logic [15:0] data_q;
    logic        tag_q;
    logic        wb_q;
    logic [7:0]  ext_hi;

    logic        wait_d;
    logic [15:0] addr_d;
    logic        rd_d;
    logic        wr_d;
    logic [7:0]  wdata_d;

    // Upper byte for a byte load, taken from the beat being completed.
    assign ext_hi = {8{SIGN_EXTEND_BYTE & bus.mem_rdata[7]}};

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.lsu_rq_start) state_nxt = LO;
            LO:   if (bus.mem_ready)    state_nxt = req.width ? HI : IDLE;
            HI:   if (bus.mem_ready)    state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Bus outputs decode only registered state and the latched request.
    always_comb begin
        wait_d  = 1'b0;
        addr_d  = 16'h0000;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        wdata_d = 8'h00;
        case (state)
            LO: begin
                wait_d  = 1'b1;
                addr_d  = req.addr;
                rd_d    = ~req.cmd;
                wr_d    = req.cmd;
                wdata_d = req.wdata[7:0];
            end
            HI: begin
                wait_d  = 1'b1;
                addr_d  = req.addr + 16'd1;
                rd_d    = ~req.cmd;
                wr_d    = req.cmd;
                wdata_d = req.wdata[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            req    <= '0;
            res_lo <= 8'h00;
            data_q <= 16'h0000;
            tag_q  <= 1'b0;
            wb_q   <= 1'b0;
        end else begin
            wb_q <= 1'b0;
            if (state == IDLE && bus.lsu_rq_start) begin
                req.cmd   <= bus.lsu_rq_cmd;
                req.width <= bus.lsu_rq_width;
                req.tag   <= bus.lsu_rq_tag;
                req.addr  <= bus.lsu_rq_addr;
                req.wdata <= bus.lsu_rq_wdata;
            end
            if (state == LO && bus.mem_ready && !req.cmd) begin
                if (req.width) begin
                    res_lo <= bus.mem_rdata;
                end else begin
                    data_q <= {ext_hi, bus.mem_rdata};
                    tag_q  <= req.tag;
                    wb_q   <= 1'b1;
                end
            end
            if (state == HI && bus.mem_ready && !req.cmd) begin
                data_q <= {bus.mem_rdata, res_lo};
                tag_q  <= req.tag;
                wb_q   <= 1'b1;
            end
        end
    end

    assign bus.lsu_wait     = wait_d;
    assign bus.mem_addr     = addr_d;
    assign bus.mem_rd       = rd_d;
    assign bus.mem_wr       = wr_d;
    assign bus.mem_wdata    = wdata_d;
    assign bus.lsu_data_in  = data_q;
    assign bus.lsu_data_tag = tag_q;
    assign bus.lsu_data_wb  = wb_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: zero-extend and sign-extend instances
// share stimulus; expected bus beats and write-backs are queued at issue time.
module tb_load_store_unit;
    logic clk;
    logic a_rst;

    load_store_unit_if ifc0 ();
    load_store_unit_if ifc1 ();

    load_store_unit #(.SIGN_EXTEND_BYTE(1'b0)) dut0 (.clk(clk), .a_rst(a_rst), .bus(ifc0.slave));
    load_store_unit #(.SIGN_EXTEND_BYTE(1'b1)) dut1 (.clk(clk), .a_rst(a_rst), .bus(ifc1.slave));

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
    } beat_t;

    typedef struct packed {
        logic        tag;
        logic [15:0] d0;
        logic [15:0] d1;
    } wb_t;

    beat_t beat_q[$];
    wb_t   wb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall_cfg = 0;
    int    stall_cnt;
    logic [7:0] rmem [0:65535];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: read data from a table, ready after stall_cfg wait cycles per beat.
    assign ifc0.mem_rdata    = rmem[ifc0.mem_addr];
    assign ifc0.mem_ready    = (stall_cnt == 0);
    assign ifc1.mem_rdata    = ifc0.mem_rdata;
    assign ifc1.mem_ready    = ifc0.mem_ready;
    assign ifc1.lsu_rq_start = ifc0.lsu_rq_start;
    assign ifc1.lsu_rq_cmd   = ifc0.lsu_rq_cmd;
    assign ifc1.lsu_rq_width = ifc0.lsu_rq_width;
    assign ifc1.lsu_rq_tag   = ifc0.lsu_rq_tag;
    assign ifc1.lsu_rq_addr  = ifc0.lsu_rq_addr;
    assign ifc1.lsu_rq_wdata = ifc0.lsu_rq_wdata;

    always @(posedge clk or posedge a_rst) begin
        if (a_rst)                                               stall_cnt <= stall_cfg;
        else if ((ifc0.mem_rd || ifc0.mem_wr) && stall_cnt > 0) stall_cnt <= stall_cnt - 1;
        else                                                     stall_cnt <= stall_cfg;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: strobed beats must match the queue head every cycle (stability while stalled).
    always @(negedge clk) begin
        if (!a_rst) begin
            if (ifc0.mem_rd || ifc0.mem_wr) begin
                chk("rd_wr_exclusive", {31'd0, ifc0.mem_rd & ifc0.mem_wr}, 32'd0);
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got addr %h wr %b expected none", ifc0.mem_addr, ifc0.mem_wr);
                end else begin
                    chk("beat_wr", {31'd0, ifc0.mem_wr}, {31'd0, beat_q[0].wr});
                    chk("beat_addr", {16'd0, ifc0.mem_addr}, {16'd0, beat_q[0].addr});
                    if (beat_q[0].wr) chk("beat_wdata", {24'd0, ifc0.mem_wdata}, {24'd0, beat_q[0].wd});
                    if (ifc0.mem_ready) void'(beat_q.pop_front());
                end
            end
            if (ifc0.lsu_data_wb) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: got data %h tag %b expected none", ifc0.lsu_data_in, ifc0.lsu_data_tag);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    chk("wb_tag", {31'd0, ifc0.lsu_data_tag}, {31'd0, e.tag});
                    chk("wb_data_zext", {16'd0, ifc0.lsu_data_in}, {16'd0, e.d0});
                    chk("wb_strobe_sext", {31'd0, ifc1.lsu_data_wb}, 32'd1);
                    chk("wb_data_sext", {16'd0, ifc1.lsu_data_in}, {16'd0, e.d1});
                end
            end
        end
    end

    task automatic issue(input logic cmd, input logic width, input logic tag,
                         input logic [15:0] addr, input logic [15:0] wdata);
        ifc0.lsu_rq_start = 1'b1;
        ifc0.lsu_rq_cmd   = cmd;
        ifc0.lsu_rq_width = width;
        ifc0.lsu_rq_tag   = tag;
        ifc0.lsu_rq_addr  = addr;
        ifc0.lsu_rq_wdata = wdata;
        @(posedge clk);
        #1 ifc0.lsu_rq_start = 1'b0;
    endtask

    // Counts lsu_wait-high cycles; ends on the first negedge with lsu_wait low.
    task automatic wait_done(input int exp, input bit toggle);
        int n = 0;
        @(negedge clk);
        while (ifc0.lsu_wait && n < 100) begin
            n++;
            if (toggle) begin
                ifc0.lsu_rq_addr  = 16'($urandom);
                ifc0.lsu_rq_wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        chk("wait_cycles", n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rmem[16'h1234] = 8'h9A;
        rmem[16'h2000] = 8'h34; rmem[16'h2001] = 8'hC2;
        rmem[16'h3000] = 8'h7F; rmem[16'h3001] = 8'h81; rmem[16'h3002] = 8'h55;
        rmem[16'h5000] = 8'h11; rmem[16'h5001] = 8'hE0;
        ifc0.lsu_rq_start = 1'b0; ifc0.lsu_rq_cmd = 1'b0; ifc0.lsu_rq_width = 1'b0;
        ifc0.lsu_rq_tag = 1'b0; ifc0.lsu_rq_addr = 16'h0; ifc0.lsu_rq_wdata = 16'h0;
        a_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wait",  {31'd0, ifc0.lsu_wait}, 32'd0);
        chk("rst_rd",    {31'd0, ifc0.mem_rd}, 32'd0);
        chk("rst_wr",    {31'd0, ifc0.mem_wr}, 32'd0);
        chk("rst_wb",    {31'd0, ifc0.lsu_data_wb}, 32'd0);
        chk("rst_addr",  {16'd0, ifc0.mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, ifc0.mem_wdata}, 32'd0);
        chk("rst_data",  {16'd0, ifc0.lsu_data_in}, 32'd0);
        chk("rst_tag",   {31'd0, ifc0.lsu_data_tag}, 32'd0);
        a_rst = 1'b0;
        @(negedge clk);

        // 1: byte load, tag 1
        beat_q.push_back('{1'b0, 16'h1234, 8'h00});
        wb_q.push_back('{1'b1, 16'h009A, 16'hFF9A});
        issue(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000);
        wait_done(1, 1'b0);

        // 2: word store across address wrap
        beat_q.push_back('{1'b1, 16'hFFFF, 8'hEF});
        beat_q.push_back('{1'b1, 16'h0000, 8'hBE});
        issue(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hBEEF);
        wait_done(2, 1'b0);
        repeat (2) @(negedge clk);

        // 3: word load, two stall cycles per beat
        stall_cfg = 2;
        beat_q.push_back('{1'b0, 16'h2000, 8'h00});
        beat_q.push_back('{1'b0, 16'h2001, 8'h00});
        wb_q.push_back('{1'b0, 16'hC234, 16'hC234});
        issue(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000);
        wait_done(6, 1'b0);
        @(negedge clk);
        stall_cfg = 0;
        @(negedge clk);

        // 4: back-to-back byte load then word load
        beat_q.push_back('{1'b0, 16'h3000, 8'h00});
        beat_q.push_back('{1'b0, 16'h3001, 8'h00});
        beat_q.push_back('{1'b0, 16'h3002, 8'h00});
        wb_q.push_back('{1'b0, 16'h007F, 16'h007F});
        wb_q.push_back('{1'b1, 16'h5581, 16'h5581});
        issue(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000);
        wait_done(1, 1'b0);
        chk("b2b_in_wb_cycle", {31'd0, ifc0.lsu_data_wb}, 32'd1);
        issue(1'b0, 1'b1, 1'b1, 16'h3001, 16'h0000);
        wait_done(2, 1'b0);
        repeat (2) @(negedge clk);

        // 5: reset in the middle of the high beat
        stall_cfg = 2;
        @(negedge clk);
        beat_q.push_back('{1'b0, 16'h5000, 8'h00});
        beat_q.push_back('{1'b0, 16'h5001, 8'h00});
        issue(1'b0, 1'b1, 1'b1, 16'h5000, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifc0.mem_rd && ifc0.mem_addr == 16'h5001) found = 1'b1;
        end
        chk("reached_hi_beat", {31'd0, found}, 32'd1);
        #1 a_rst = 1'b1;
        #1;
        chk("midrst_wait", {31'd0, ifc0.lsu_wait}, 32'd0);
        chk("midrst_rd",   {31'd0, ifc0.mem_rd}, 32'd0);
        chk("midrst_addr", {16'd0, ifc0.mem_addr}, 32'd0);
        chk("midrst_data", {16'd0, ifc0.lsu_data_in}, 32'd0);
        beat_q.delete();
        wb_q.delete();
        @(posedge clk);
        @(negedge clk);
        stall_cfg = 0;
        a_rst = 1'b0;
        repeat (4) @(negedge clk);
        beat_q.push_back('{1'b0, 16'h5001, 8'h00});
        wb_q.push_back('{1'b0, 16'h00E0, 16'hFFE0});
        issue(1'b0, 1'b0, 1'b0, 16'h5001, 16'h0000);
        wait_done(1, 1'b0);
        repeat (2) @(negedge clk);

        // 6: request inputs toggled during a stalled word store
        stall_cfg = 2;
        @(negedge clk);
        beat_q.push_back('{1'b1, 16'h4000, 8'h22});
        beat_q.push_back('{1'b1, 16'h4001, 8'h11});
        issue(1'b1, 1'b1, 1'b0, 16'h4000, 16'h1122);
        wait_done(6, 1'b1);
        repeat (3) @(negedge clk);

        chk("beats_drained", beat_q.size(), 32'd0);
        chk("wbs_drained", wb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
